// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
// Shared definitions for the input debouncer:
//   - 2-bit state encodings of the debounce FSM
//   - default qualification length (DEBOUNCE_CYCLES)
//   - small decode helpers for the FSM outputs
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

  localparam logic [1:0] ENC_STABLE_LO = 2'd0;
  localparam logic [1:0] ENC_WAIT_HI   = 2'd1;
  localparam logic [1:0] ENC_STABLE_HI = 2'd2;
  localparam logic [1:0] ENC_WAIT_LO   = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LO = ENC_STABLE_LO,
    WAIT_HI   = ENC_WAIT_HI,
    STABLE_HI = ENC_STABLE_HI,
    WAIT_LO   = ENC_WAIT_LO
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Level presented on debounced_out while the FSM sits in a given state.
  function automatic logic state_level(input deb_state_t st);
    return (st == STABLE_HI) || (st == WAIT_LO);
  endfunction

  // High while a candidate transition is being qualified.
  function automatic logic state_waiting(input deb_state_t st);
    return (st == WAIT_HI) || (st == WAIT_LO);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer for a single asynchronous bit. Reusable for any
// asynchronous input entering the clk domain.
// Ports:
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset; all flops load RESET_LEVEL
//   async_in - asynchronous input bit
//   sync_out - synchronized bit, SYNC_STAGES clk edges behind async_in
// -----------------------------------------------------------------------------
module bit_synchronizer #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Turns a raw, asynchronous, bouncy input into a clean clk-synchronous level.
// noisy_in is synchronized, then a 4-state FSM accepts a new level only after
// DEBOUNCE_CYCLES consecutive identical synchronized samples. Aborted
// qualifications are counted in a saturating diagnostic counter.
// Ports:
//   clk           - system clock
//   reset_n       - asynchronous active-low reset
//   noisy_in      - raw asynchronous input
//   glitch_clr    - synchronous clear of glitch_count (wins over an increment)
//   debounced_out - clean registered level, feeds the edge-detection stage
//   settling      - registered, high while a candidate transition is qualified
//   glitch_count  - saturating count of aborted transitions
// -----------------------------------------------------------------------------
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = 8,
  parameter int   GLITCH_W        = 8,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                noisy_in,
  input  logic                glitch_clr,
  output logic                debounced_out,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam deb_state_t          RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_ZERO = {GLITCH_W{1'b0}};
  localparam logic [GLITCH_W-1:0] GLITCH_ONE  = GLITCH_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX  = {GLITCH_W{1'b1}};
  // With a one-sample qualification the WAIT states are skipped entirely.
  localparam logic                ACCEPT_NOW  = (DEBOUNCE_CYCLES == 1);

  logic             sync_in_s;
  logic             glitch_s;
  deb_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (noisy_in),
    .sync_out (sync_in_s)
  );

  // A qualification aborts when the synchronized input falls back to the old
  // level; this includes the final counting sample.
  assign glitch_s = ((state_r == WAIT_HI) && !sync_in_s) ||
                    ((state_r == WAIT_LO) &&  sync_in_s);

  // Debounce FSM; outputs are loaded with the decode of the state being entered
  // so they are registered and aligned with state_r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RESET_STATE;
      cnt_r         <= CNT_ZERO;
      debounced_out <= RESET_LEVEL;
      settling      <= 1'b0;
    end else begin
      case (state_r)
        STABLE_LO: begin
          if (sync_in_s && ACCEPT_NOW) begin
            state_r       <= STABLE_HI;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_HI);
            settling      <= state_waiting(STABLE_HI);
          end else if (sync_in_s) begin
            state_r       <= WAIT_HI;
            cnt_r         <= CNT_ONE;
            debounced_out <= state_level(WAIT_HI);
            settling      <= state_waiting(WAIT_HI);
          end else begin
            state_r       <= STABLE_LO;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_LO);
            settling      <= state_waiting(STABLE_LO);
          end
        end
        WAIT_HI: begin
          if (sync_in_s && (cnt_r == CNT_LAST)) begin
            state_r       <= STABLE_HI;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_HI);
            settling      <= state_waiting(STABLE_HI);
          end else if (sync_in_s) begin
            state_r       <= WAIT_HI;
            cnt_r         <= cnt_r + CNT_ONE;
            debounced_out <= state_level(WAIT_HI);
            settling      <= state_waiting(WAIT_HI);
          end else begin
            state_r       <= STABLE_LO;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_LO);
            settling      <= state_waiting(STABLE_LO);
          end
        end
        STABLE_HI: begin
          if (!sync_in_s && ACCEPT_NOW) begin
            state_r       <= STABLE_LO;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_LO);
            settling      <= state_waiting(STABLE_LO);
          end else if (!sync_in_s) begin
            state_r       <= WAIT_LO;
            cnt_r         <= CNT_ONE;
            debounced_out <= state_level(WAIT_LO);
            settling      <= state_waiting(WAIT_LO);
          end else begin
            state_r       <= STABLE_HI;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_HI);
            settling      <= state_waiting(STABLE_HI);
          end
        end
        WAIT_LO: begin
          if (!sync_in_s && (cnt_r == CNT_LAST)) begin
            state_r       <= STABLE_LO;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_LO);
            settling      <= state_waiting(STABLE_LO);
          end else if (!sync_in_s) begin
            state_r       <= WAIT_LO;
            cnt_r         <= cnt_r + CNT_ONE;
            debounced_out <= state_level(WAIT_LO);
            settling      <= state_waiting(WAIT_LO);
          end else begin
            state_r       <= STABLE_HI;
            cnt_r         <= CNT_ZERO;
            debounced_out <= state_level(STABLE_HI);
            settling      <= state_waiting(STABLE_HI);
          end
        end
        default: begin
          state_r       <= RESET_STATE;
          cnt_r         <= CNT_ZERO;
          debounced_out <= RESET_LEVEL;
          settling      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear in the same cycle as a glitch wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count <= GLITCH_ZERO;
    end else if (glitch_clr) begin
      glitch_count <= GLITCH_ZERO;
    end else if (glitch_s && (glitch_count != GLITCH_MAX)) begin
      glitch_count <= glitch_count + GLITCH_ONE;
    end else begin
      glitch_count <= glitch_count;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Directed bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// GLITCH_W=4. dut0 uses RESET_LEVEL=0, dut1 uses RESET_LEVEL=1 and only sees
// a held-low input. Edge numbers in comments count rising edges after the
// reset release; inputs change and outputs are sampled 1 time unit after an
// edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

  logic       clk;
  logic       reset_n;
  logic       noisy0, noisy1;
  logic       clr0, clr1;
  logic       deb0, deb1;
  logic       set0, set1;
  logic [3:0] g0, g1;

  int checks;
  int errors;

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8),
    .GLITCH_W        (4),
    .RESET_LEVEL     (1'b0)
  ) dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .noisy_in      (noisy0),
    .glitch_clr    (clr0),
    .debounced_out (deb0),
    .settling      (set0),
    .glitch_count  (g0)
  );

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8),
    .GLITCH_W        (4),
    .RESET_LEVEL     (1'b1)
  ) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .noisy_in      (noisy1),
    .glitch_clr    (clr1),
    .debounced_out (deb1),
    .settling      (set1),
    .glitch_count  (g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    noisy0  = 1'b0;
    noisy1  = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;

    // Reset state
    step(2);
    chk("rst_deb0", {7'd0, deb0}, 8'd0);
    chk("rst_set0", {7'd0, set0}, 8'd0);
    chk("rst_g0",   {4'd0, g0},   8'd0);
    chk("rst_deb1", {7'd0, deb1}, 8'd1);
    chk("rst_set1", {7'd0, set1}, 8'd0);
    reset_n = 1'b1;

    // Clean rise on dut0 (input before edge 5), falling path on dut1
    step(4);                                        // e4
    chk("fall1_wait_set", {7'd0, set1}, 8'd1);
    chk("fall1_wait_deb", {7'd0, deb1}, 8'd1);
    noisy0 = 1'b1;
    step(1);                                        // e5
    chk("fall1_e5_deb", {7'd0, deb1}, 8'd1);
    step(1);                                        // e6
    chk("fall1_e6_deb", {7'd0, deb1}, 8'd0);
    chk("fall1_e6_set", {7'd0, set1}, 8'd0);
    step(1);                                        // e7
    chk("rise_e7_set", {7'd0, set0}, 8'd1);
    chk("rise_e7_deb", {7'd0, deb0}, 8'd0);
    step(2);                                        // e9
    chk("rise_e9_set", {7'd0, set0}, 8'd1);
    chk("rise_e9_deb", {7'd0, deb0}, 8'd0);
    step(1);                                        // e10
    chk("rise_e10_deb", {7'd0, deb0}, 8'd1);
    chk("rise_e10_set", {7'd0, set0}, 8'd0);
    chk("rise_e10_g",   {4'd0, g0},   8'd0);

    // Clean fall on dut0 back to low (input before edge 11)
    noisy0 = 1'b0;
    step(5);                                        // e15
    chk("fall0_e15_deb", {7'd0, deb0}, 8'd1);
    chk("fall0_e15_set", {7'd0, set0}, 8'd1);
    step(1);                                        // e16
    chk("fall0_e16_deb", {7'd0, deb0}, 8'd0);
    chk("fall0_e16_g",   {4'd0, g0},   8'd0);

    // Bounce 1,0,1,0 then hold 0
    noisy0 = 1'b1; step(1);                         // e17
    noisy0 = 1'b0; step(1);                         // e18
    noisy0 = 1'b1; step(1);                         // e19
    noisy0 = 1'b0; step(1);                         // e20
    chk("bounce_e20_g", {4'd0, g0}, 8'd1);
    step(1);                                        // e21
    chk("bounce_e21_set", {7'd0, set0}, 8'd1);
    step(1);                                        // e22
    chk("bounce_e22_g",   {4'd0, g0},   8'd2);
    chk("bounce_e22_set", {7'd0, set0}, 8'd0);
    step(4);                                        // e26
    chk("bounce_e26_deb", {7'd0, deb0}, 8'd0);
    chk("bounce_e26_g",   {4'd0, g0},   8'd2);

    // Late glitch: 3 high samples, low on the final counting sample
    noisy0 = 1'b1; step(3);                         // e29
    noisy0 = 1'b0; step(2);                         // e31
    chk("late_e31_set", {7'd0, set0}, 8'd1);
    chk("late_e31_g",   {4'd0, g0},   8'd2);
    step(1);                                        // e32
    chk("late_e32_g",   {4'd0, g0},   8'd3);
    chk("late_e32_deb", {7'd0, deb0}, 8'd0);
    chk("late_e32_set", {7'd0, set0}, 8'd0);

    // Exactly 4 high samples are accepted
    noisy0 = 1'b1; step(4);                         // e36
    noisy0 = 1'b0; step(1);                         // e37
    chk("four_e37_deb", {7'd0, deb0}, 8'd0);
    chk("four_e37_set", {7'd0, set0}, 8'd1);
    step(1);                                        // e38
    chk("four_e38_deb", {7'd0, deb0}, 8'd1);
    chk("four_e38_g",   {4'd0, g0},   8'd3);
    step(4);                                        // e42
    chk("four_e42_deb", {7'd0, deb0}, 8'd0);
    chk("four_e42_g",   {4'd0, g0},   8'd3);

    // Saturation: 20 glitch events on top of the 3 already counted
    for (int i = 0; i < 11; i++) begin
      noisy0 = 1'b1; step(1);
      noisy0 = 1'b0; step(1);
    end
    step(2);
    chk("sat_14", {4'd0, g0}, 8'd14);
    for (int i = 0; i < 9; i++) begin
      noisy0 = 1'b1; step(1);
      noisy0 = 1'b0; step(1);
    end
    step(2);
    chk("sat_hold_15", {4'd0, g0},   8'd15);
    chk("sat_deb",     {7'd0, deb0}, 8'd0);
    chk("sat_g1",      {4'd0, g1},   8'd0);

    // Clear in the same cycle as a glitch event
    noisy0 = 1'b1; step(1);
    noisy0 = 1'b0; step(1);
    step(1);
    chk("clr_pre_set", {7'd0, set0}, 8'd1);
    chk("clr_pre_g",   {4'd0, g0},   8'd15);
    clr0 = 1'b1;
    step(1);
    clr0 = 1'b0;
    chk("clr_g",   {4'd0, g0},   8'd0);
    chk("clr_set", {7'd0, set0}, 8'd0);
    chk("clr_deb", {7'd0, deb0}, 8'd0);

    // Counting resumes after the clear
    noisy0 = 1'b1; step(1);
    noisy0 = 1'b0; step(1);
    step(2);
    chk("post_clr_g", {4'd0, g0}, 8'd1);

    // Asynchronous reset while qualifying a rise
    noisy0 = 1'b1;
    step(3);
    chk("rst_mid_pre_set", {7'd0, set0}, 8'd1);
    chk("rst_mid_pre_d1",  {7'd0, deb1}, 8'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_deb0", {7'd0, deb0}, 8'd0);
    chk("rst_mid_set0", {7'd0, set0}, 8'd0);
    chk("rst_mid_g0",   {4'd0, g0},   8'd0);
    chk("rst_mid_deb1", {7'd0, deb1}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
